// File: rtl/gcd_initiator.sv
// gcd_initiator: takes jobs from a valid/ready stream, drives a start/busy/valid accelerator, returns results on a valid/ready stream.
// Optional define GCD_INIT_CHECK_EN: compare each result against the job's expected value and count mismatches.
module gcd_initiator #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic [WIDTH-1:0]     job_a_i,
  input  logic [WIDTH-1:0]     job_b_i,
  input  logic [WIDTH-1:0]     job_exp_i,
  output logic                 acc_start_o,
  output logic [WIDTH-1:0]     acc_a_o,
  output logic [WIDTH-1:0]     acc_b_o,
  input  logic                 acc_busy_i,
  input  logic                 acc_valid_i,
  input  logic [WIDTH-1:0]     acc_result_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [WIDTH-1:0]     res_data_o,
  output logic                 res_match_o,
  output logic                 res_timeout_o,
  output logic [CNT_WIDTH-1:0] jobs_done_o,
  output logic [CNT_WIDTH-1:0] errors_o
);

  localparam int unsigned          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]        TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     res_q;
  logic                 match_q;
  logic                 timeout_q;
  logic [TW-1:0]        to_cnt_q;
  logic [TW-1:0]        to_cnt_d;
  logic [CNT_WIDTH-1:0] done_q;
  logic [CNT_WIDTH-1:0] done_d;
  logic [CNT_WIDTH-1:0] err_q;
  logic [CNT_WIDTH-1:0] err_d;
  logic                 job_fire_s;
  logic                 start_s;
  logic                 match_cap_s;
  logic                 err_inc_s;

`ifdef GCD_INIT_CHECK_EN
  logic [WIDTH-1:0] exp_q;

  // Expected value travels with the operands of the job in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_q <= {WIDTH{1'b0}};
    end else if (job_fire_s) begin
      exp_q <= job_exp_i;
    end else begin
      exp_q <= exp_q;
    end
  end

  assign match_cap_s = (acc_result_i == exp_q);
`else
  logic unused_exp_s;
  assign unused_exp_s = ^job_exp_i;
  assign match_cap_s  = 1'b1;
`endif

  // Ready is masked during reset because the reset state itself is IDLE.
  assign job_ready_o = (state_q == ST_IDLE) & ~rst_i;
  assign job_fire_s  = job_valid_i & job_ready_o;
  assign start_s     = (state_q == ST_ISSUE) & ~acc_busy_i;
  assign err_inc_s   = timeout_q | ~match_q;

  assign acc_start_o   = start_s;
  assign acc_a_o       = a_q;
  assign acc_b_o       = b_q;
  assign res_valid_o   = (state_q == ST_RESP);
  assign res_data_o    = res_q;
  assign res_match_o   = match_q;
  assign res_timeout_o = timeout_q;
  assign jobs_done_o   = done_q;
  assign errors_o      = err_q;

  // Saturating counter and timeout increments.
  always_comb begin
    to_cnt_d = to_cnt_q + TW'(1);
    done_d   = done_q;
    err_d    = err_q;
    if (done_q != CNT_MAX) begin
      done_d = done_q + CNT_WIDTH'(1);
    end else begin
      done_d = done_q;
    end
    if (err_inc_s && (err_q != CNT_MAX)) begin
      err_d = err_q + CNT_WIDTH'(1);
    end else begin
      err_d = err_q;
    end
  end

  // Job sequencing FSM with its datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      res_q     <= {WIDTH{1'b0}};
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      to_cnt_q  <= {TW{1'b0}};
      done_q    <= {CNT_WIDTH{1'b0}};
      err_q     <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (job_fire_s) begin
            a_q     <= job_a_i;
            b_q     <= job_b_i;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (start_s) begin
            to_cnt_q <= {TW{1'b0}};
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A valid in the expiry cycle still wins over the timeout.
          if (acc_valid_i) begin
            res_q     <= acc_result_i;
            match_q   <= match_cap_s;
            timeout_q <= 1'b0;
            state_q   <= ST_RESP;
          end else if (to_cnt_q == TO_LAST) begin
            res_q     <= {WIDTH{1'b0}};
            match_q   <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ST_RESP;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        ST_RESP: begin
          if (res_ready_i) begin
            done_q  <= done_d;
            err_q   <= err_d;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gcd_initiator.md
Name: gcd_initiator

Overview:
- Hardware initiator for the start/busy/valid compute interface used by the gcd accelerator. It replaces the software-style sequencing with RTL that can be placed in front of the accelerator.
- Accepts operand jobs on a valid/ready input stream and issues a one-cycle start to the accelerator. It then waits for the accelerator's valid and returns the result on a valid/ready output stream.
- Optionally compares each result with a per-job expected value, and keeps done and error counters.

Parameters:
- WIDTH, 32, operand/result width.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before the job is aborted as timed out; must be >= 1.
- CNT_WIDTH, 16, width of the job and error counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- job_valid_i  in  1  job available.
- job_ready_o  out  1  initiator accepts a job this cycle.
- job_a_i  in  WIDTH  operand a.
- job_b_i  in  WIDTH  operand b.
- job_exp_i  in  WIDTH  expected result; used only with GCD_INIT_CHECK_EN.
- acc_start_o  out  1  start pulse to the accelerator.
- acc_a_o  out  WIDTH  operand a to the accelerator.
- acc_b_o  out  WIDTH  operand b to the accelerator.
- acc_busy_i  in  1  accelerator busy.
- acc_valid_i  in  1  accelerator result valid.
- acc_result_i  in  WIDTH  accelerator result.
- res_valid_o  out  1  response available.
- res_ready_i  in  1  consumer accepts the response.
- res_data_o  out  WIDTH  captured result; 0 on timeout.
- res_match_o  out  1  result equals expected.
- res_timeout_o  out  1  job aborted by timeout.
- jobs_done_o  out  CNT_WIDTH  responses delivered.
- errors_o  out  CNT_WIDTH  mismatches plus timeouts.

Behaviour:
- Reset values: all outputs 0, except job_ready_o, which is also 0 while rst_i is high. State = IDLE. Operand, result and flag registers = 0. Counters = 0.
- The reset is asynchronous. Asserting it mid-job returns the block to IDLE immediately and drops acc_start_o and res_valid_o with no response issued. Counters clear.
- Accelerator contract:
  - The accelerator samples acc_a_o and acc_b_o on the edge where acc_start_o is 1.
  - It clears acc_valid_i on that same edge.
  - acc_valid_i may be a pulse or a level. Only the first cycle with acc_valid_i = 1 while in WAIT is used.
- State machine, IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
  - IDLE: job_ready_o = 1. When job_valid_i = 1, latch a, b and exp, then go to ISSUE.
  - ISSUE: acc_start_o = acc_busy_i ? 0 : 1. If start is driven, go to WAIT next cycle, so the start pulse is exactly 1 cycle. Otherwise hold in ISSUE with start low.
  - WAIT:
    - acc_start_o = 0. A timeout counter starts at 0 on entry and increments each cycle.
    - If acc_valid_i = 1: capture acc_result_i, set timeout flag 0, go to RESP.
    - Otherwise, if counter = TIMEOUT_CYCLES-1: set res_data 0, set timeout flag 1, go to RESP.
    - If valid arrives in the same cycle the counter expires, valid takes precedence.
  - RESP: res_valid_o = 1 and outputs stable until res_ready_i = 1. On that handshake:
    - jobs_done increments;
    - errors increments if timeout or mismatch;
    - go to IDLE.
- acc_a_o and acc_b_o hold the latched operands from ISSUE until the next job is latched.
- job_ready_o is 0 outside IDLE, so there is at most one job in flight.
- Minimum latency, with the accelerator idle:
  - job handshake at cycle N;
  - start at N+1;
  - earliest valid seen at N+2;
  - res_valid_o at N+3.
- Counters saturate at all-ones and do not wrap.
- res_match_o is computed at capture time. On timeout, res_match_o = 0.

Optional Feature:
- Macro: GCD_INIT_CHECK_EN.
- Defined:
  - res_match_o = (acc_result_i == latched exp) at capture;
  - a mismatch counts in errors_o.
- Undefined:
  - job_exp_i is ignored and not registered;
  - res_match_o = 1 for non-timeout responses and 0 for timeouts;
  - errors_o counts timeouts only.

Test Plan:
- Job a=48, b=18, exp=6; accelerator returns 6 after 5 cycles -> one acc_start_o pulse carrying 48/18; res_data_o=6, res_match_o=1, res_timeout_o=0; jobs_done_o=1, errors_o=0.
- With GCD_INIT_CHECK_EN: job a=35, b=14, exp=5; accelerator returns 7 -> res_match_o=0, errors_o=1. Without the macro: res_match_o=1, errors_o=0.
- TIMEOUT_CYCLES=16, accelerator never asserts valid -> res_valid_o exactly 16 cycles after entering WAIT; res_timeout_o=1, res_data_o=0, errors_o=1.
- acc_busy_i held 1 for 4 cycles at ISSUE -> no start during busy; start issued on the first cycle busy=0; job_ready_o stays 0 throughout.
- res_ready_i low for 5 cycles, with acc_valid_i held high as a level -> response data stable; no second capture; a back-to-back second job (a=100, b=75, exp=25) accepted only after the handshake and yields 25.
- rst_i asserted mid-WAIT -> outputs 0 asynchronously; after release, a new job a=17, b=5, exp=1 completes normally with jobs_done_o=1.
